regfile_sb: RTL and testbench

//   Write-back sink: 32x32 GPR file consumed by the ID stage. Accepts the WB

---
 rtl/regfile_sb.sv | 69 ++++++
 tb/tb_regfile_sb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: 32x32 GPR file with per-register in-flight writer scoreboard; RF_BYPASS_EN enables same-cycle write-back bypass.
module regfile_sb #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] ws_to_rf_bus,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    output logic        busy1,
    output logic        busy2,
    input  logic        issue_valid,
    input  logic [4:0]  issue_dest,
    output logic        sb_error
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX = '1;
    logic             we;
    logic [4:0]       waddr;
    logic [31:0]      wdata;
    logic [31:0]      gpr     [32];
    logic [CNT_W-1:0] cnt     [32];
    logic [CNT_W-1:0] cnt_nxt [32];
    logic [31:0]      inc_v;
    logic [31:0]      dec_v;
    logic             err;
    assign we    = ws_to_rf_bus[37];
    assign waddr = ws_to_rf_bus[36:32];
    assign wdata = ws_to_rf_bus[31:0];
    // one-hot issue/retire vectors; bit 0 never set so r0 is never tracked
    assign inc_v = (issue_valid && issue_dest != 5'd0) ? (32'd1 << issue_dest) : 32'd0;
    assign dec_v = (we && waddr != 5'd0) ? (32'd1 << waddr) : 32'd0;
    always_comb begin
        err = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cnt_nxt[i] = (inc_v[i] && !dec_v[i] && cnt[i] != MAX) ? cnt[i] + ONE :
                         (dec_v[i] && !inc_v[i] && cnt[i] != '0)  ? cnt[i] - ONE : cnt[i];
            err = err | (inc_v[i] & ~dec_v[i] & (cnt[i] == MAX))
                      | (dec_v[i] & ~inc_v[i] & (cnt[i] == '0));
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= '0;
                cnt[i] <= '0;
            end
            sb_error <= 1'b0;
        end else begin
            if (we && waddr != 5'd0) gpr[waddr] <= wdata;
            for (int i = 0; i < 32; i++) cnt[i] <= cnt_nxt[i];
            sb_error <= sb_error | err;
        end
    end
`ifdef RF_BYPASS_EN
    // the retiring writer no longer blocks ID; its data is forwarded instead
    assign rdata1 = (raddr1 == 5'd0) ? '0 : (we && waddr == raddr1) ? wdata : gpr[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : (we && waddr == raddr2) ? wdata : gpr[raddr2];
    assign busy1  = (raddr1 != 5'd0) && (cnt[raddr1] > CNT_W'(dec_v[raddr1]));
    assign busy2  = (raddr2 != 5'd0) && (cnt[raddr2] > CNT_W'(dec_v[raddr2]));
`else
    assign rdata1 = (raddr1 == 5'd0) ? '0 : gpr[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : gpr[raddr2];
    assign busy1  = (raddr1 != 5'd0) && (cnt[raddr1] != '0);
    assign busy2  = (raddr2 != 5'd0) && (cnt[raddr2] != '0);
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against a behavioural model.
module tb_regfile_sb;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [37:0] ws_to_rf_bus;
    logic [4:0]  raddr1, raddr2, issue_dest;
    logic        issue_valid;
    logic [31:0] rdata1, rdata2;
    logic        busy1, busy2, sb_error;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_gpr [32];
    int          m_cnt [32];
    bit          m_err;
    assign ws_to_rf_bus = {we, waddr, wdata};
    always #5 clk = ~clk;
    regfile_sb #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ws_to_rf_bus(ws_to_rf_bus),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
        .busy1(busy1), .busy2(busy2), .issue_valid(issue_valid),
        .issue_dest(issue_dest), .sb_error(sb_error)
    );
    // model advances on the same edge using the inputs held across it
    task automatic step();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_gpr[i] = 32'h0;
                m_cnt[i] = 0;
            end
            m_err = 1'b0;
        end else begin
            if (we && waddr != 0) m_gpr[waddr] = wdata;
            if (!(issue_valid && issue_dest != 0 && we && waddr == issue_dest)) begin
                if (issue_valid && issue_dest != 0) begin
                    if (m_cnt[issue_dest] == MAXC) m_err = 1'b1;
                    else m_cnt[issue_dest]++;
                end
                if (we && waddr != 0) begin
                    if (m_cnt[waddr] == 0) m_err = 1'b1;
                    else m_cnt[waddr]--;
                end
            end
        end
        #1;
    endtask
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (BYP && we && waddr == a) return wdata;
        return m_gpr[a];
    endfunction
    function automatic logic exp_busy(input logic [4:0] a);
        int lim = (BYP && we && waddr == a) ? 1 : 0;
        return (a != 0) && (m_cnt[a] > lim);
    endfunction
    task automatic idle();
        we = 1'b0; waddr = 5'd0; wdata = 32'h0; issue_valid = 1'b0; issue_dest = 5'd0;
    endtask
    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask
    task automatic test_reset();
        idle();
        raddr1 = 5'd0; raddr2 = 5'd0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        raddr1 = 5'd5; raddr2 = 5'd31;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h want 0", rdata1); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata2: got %h want 0", rdata2); end
        checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b want 00", busy1, busy2); end
        checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL reset_sb_error: got %b want 0", sb_error); end
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL r0_bypass: got %h want 0", rdata1); end
        step();
        idle();
        #1;
        checks++; if (rdata1 !== 32'h0 || busy1 !== 1'b0) begin errors++; $display("FAIL r0_write: got %h/%b want 0/0", rdata1, busy1); end
    endtask
    task automatic test_write_read();
        idle();
        we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; raddr2 = 5'd5;
        #1;
        checks++; if (rdata2 !== (BYP ? 32'h1234_5678 : 32'h0)) begin errors++; $display("FAIL wr_same_cycle: got %h want %h", rdata2, BYP ? 32'h1234_5678 : 32'h0); end
        step();
        idle();
        #1;
        checks++; if (rdata2 !== 32'h1234_5678) begin errors++; $display("FAIL wr_next_cycle: got %h want 12345678", rdata2); end
    endtask
    task automatic test_scoreboard();
        do_reset();
        raddr1 = 5'd8;
        issue_valid = 1'b1; issue_dest = 5'd8;
        step();
        step();
        idle();
        #1;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_two_issued: got %b want 1", busy1); end
        we = 1'b1; waddr = 5'd8; wdata = 32'hAAAA_0001;
        #1;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_first_retire_cycle: got %b want 1", busy1); end
        step();
        idle();
        #1;
        checks++; if (busy1 !== 1'b1 || rdata1 !== 32'hAAAA_0001) begin errors++; $display("FAIL sb_one_left: got %b/%h want 1/aaaa0001", busy1, rdata1); end
        we = 1'b1; waddr = 5'd8; wdata = 32'hBBBB_0002;
        #1;
        checks++; if (busy1 !== !BYP) begin errors++; $display("FAIL sb_last_retire_busy: got %b want %b", busy1, !BYP); end
        checks++; if (rdata1 !== (BYP ? 32'hBBBB_0002 : 32'hAAAA_0001)) begin errors++; $display("FAIL sb_last_retire_data: got %h want %h", rdata1, BYP ? 32'hBBBB_0002 : 32'hAAAA_0001); end
        step();
        idle();
        #1;
        checks++; if (busy1 !== 1'b0 || rdata1 !== 32'hBBBB_0002 || sb_error !== 1'b0) begin errors++; $display("FAIL sb_drained: got %b/%h/%b want 0/bbbb0002/0", busy1, rdata1, sb_error); end
    endtask
    task automatic test_same_cycle();
        do_reset();
        raddr1 = 5'd3;
        issue_valid = 1'b1; issue_dest = 5'd3;
        step();
        we = 1'b1; waddr = 5'd3; wdata = 32'h0000_3333;
        step();
        idle();
        #1;
        checks++; if (busy1 !== 1'b1 || sb_error !== 1'b0 || rdata1 !== 32'h3333) begin errors++; $display("FAIL same_cycle: got %b/%b/%h want 1/0/00003333", busy1, sb_error, rdata1); end
        we = 1'b1; waddr = 5'd3; wdata = 32'h0000_4444;
        step();
        idle();
        #1;
        checks++; if (busy1 !== 1'b0 || sb_error !== 1'b0) begin errors++; $display("FAIL same_cycle_drain: got %b/%b want 0/0", busy1, sb_error); end
    endtask
    task automatic test_saturate();
        do_reset();
        raddr2 = 5'd9;
        issue_valid = 1'b1; issue_dest = 5'd9;
        for (int k = 0; k < MAXC; k++) step();
        idle();
        #1;
        checks++; if (busy2 !== 1'b1 || sb_error !== 1'b0) begin errors++; $display("FAIL sat_full: got %b/%b want 1/0", busy2, sb_error); end
        issue_valid = 1'b1; issue_dest = 5'd9;
        step();
        idle();
        step();
        #1;
        checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL sat_overflow_err: got %b want 1", sb_error); end
        we = 1'b1; waddr = 5'd9;
        for (int k = 0; k < MAXC; k++) step();
        idle();
        #1;
        checks++; if (busy2 !== 1'b0 || sb_error !== 1'b1) begin errors++; $display("FAIL sat_held_at_max: got %b/%b want 0/1", busy2, sb_error); end
    endtask
    task automatic test_underflow();
        do_reset();
        we = 1'b1; waddr = 5'd7; wdata = 32'h7777_0007;
        step();
        idle();
        raddr1 = 5'd7;
        #1;
        checks++; if (rdata1 !== 32'h7777_0007 || sb_error !== 1'b1) begin errors++; $display("FAIL underflow: got %h/%b want 77770007/1", rdata1, sb_error); end
        reset = 1'b1;
        we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
        step();
        reset = 1'b0;
        idle();
        #1;
        checks++; if (rdata1 !== 32'h0 || sb_error !== 1'b0) begin errors++; $display("FAIL reset_clears: got %h/%b want 0/0", rdata1, sb_error); end
    endtask
    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            reset       = ($urandom_range(0, 39) == 0);
            we          = 1'($urandom_range(0, 1));
            waddr       = 5'($urandom_range(0, 7));
            wdata       = $urandom;
            issue_valid = 1'($urandom_range(0, 1));
            issue_dest  = 5'($urandom_range(0, 7));
            raddr1      = 5'($urandom_range(0, 7));
            raddr2      = 5'($urandom_range(0, 7));
            #1;
            checks++; if (rdata1 !== exp_rd(raddr1)) begin errors++; $display("FAIL rnd_rdata1 @%0d: got %h want %h", k, rdata1, exp_rd(raddr1)); end
            checks++; if (rdata2 !== exp_rd(raddr2)) begin errors++; $display("FAIL rnd_rdata2 @%0d: got %h want %h", k, rdata2, exp_rd(raddr2)); end
            checks++; if (busy1 !== exp_busy(raddr1)) begin errors++; $display("FAIL rnd_busy1 @%0d: got %b want %b", k, busy1, exp_busy(raddr1)); end
            checks++; if (busy2 !== exp_busy(raddr2)) begin errors++; $display("FAIL rnd_busy2 @%0d: got %b want %b", k, busy2, exp_busy(raddr2)); end
            checks++; if (sb_error !== m_err) begin errors++; $display("FAIL rnd_sb_error @%0d: got %b want %b", k, sb_error, m_err); end
            step();
        end
        reset = 1'b0;
        idle();
    endtask
    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_same_cycle();
        test_saturate();
        test_underflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
